// File: rtl/div_recon_mul.sv
// rtl/div_recon_mul.sv - iterative signed q*d + r reconstruction stage with a sideband tag
// Optional dividend cross-check is enabled by defining DIV_RECON_CHECK_EN.
module div_recon_mul #(
    parameter int W     = 35,
    parameter int STEP  = 1,
    parameter int TAG_W = 35
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       in_quot,
    input  logic [W-1:0]       in_divisor,
    input  logic [W-1:0]       in_rem,
    input  logic [TAG_W-1:0]   in_tag,
`ifdef DIV_RECON_CHECK_EN
    input  logic [W-1:0]       in_dividend,
    output logic               out_mismatch,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*W-1:0]     out_result,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int ITERS = (W + STEP - 1) / STEP;
    localparam int CW    = $clog2(ITERS + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIN, DONE} state_t;

    state_t           state;
    logic [W-1:0]     mult;
    logic [2*W-1:0]   mcand;
    logic [2*W-1:0]   acc;
    logic [2*W-1:0]   rem_ext;
    logic             sign;
    logic [CW-1:0]    cnt;
`ifdef DIV_RECON_CHECK_EN
    logic [W-1:0]     dividend_q;
`endif

    // Magnitude of a two's complement value; -2^(W-1) maps to 2^(W-1) as unsigned.
    function automatic logic [W-1:0] mag(input logic [W-1:0] x);
        return x[W-1] ? (~x + 1'b1) : x;
    endfunction

    logic [2*W-1:0] low_ext;
    logic [2*W-1:0] pp;
    logic [2*W-1:0] fin_val;

    always_comb begin
        low_ext = {{(2*W-STEP){1'b0}}, mult[STEP-1:0]};
        pp      = mcand * low_ext;
        fin_val = (sign ? (~acc + 1'b1) : acc) + rem_ext;
    end

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mult       <= '0;
            mcand      <= '0;
            acc        <= '0;
            rem_ext    <= '0;
            sign       <= 1'b0;
            cnt        <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
`ifdef DIV_RECON_CHECK_EN
            dividend_q   <= '0;
            out_mismatch <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mult    <= mag(in_quot);
                        mcand   <= {{W{1'b0}}, mag(in_divisor)};
                        sign    <= in_quot[W-1] ^ in_divisor[W-1];
                        rem_ext <= {{W{in_rem[W-1]}}, in_rem};
                        out_tag <= in_tag;
                        acc     <= '0;
                        cnt     <= '0;
`ifdef DIV_RECON_CHECK_EN
                        dividend_q <= in_dividend;
`endif
                        state   <= CALC;
                    end
                end
                CALC: begin
                    acc   <= acc + pp;
                    mult  <= mult >> STEP;
                    mcand <= mcand << STEP;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(ITERS - 1))
                        state <= FIN;
                end
                FIN: begin
                    out_result <= fin_val;
                    out_valid  <= 1'b1;
`ifdef DIV_RECON_CHECK_EN
                    out_mismatch <= (fin_val != {{W{dividend_q[W-1]}}, dividend_q});
`endif
                    state      <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
`ifdef DIV_RECON_CHECK_EN
                        out_mismatch <= 1'b0;
`endif
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_recon_mul.sv
// tb/tb_div_recon_mul.sv - randomized self-checking bench for div_recon_mul against an arithmetic model
module tb_div_recon_mul;

    localparam int W     = 35;
    localparam int STEP  = 1;
    localparam int TAG_W = 35;
    localparam int ITERS = (W + STEP - 1) / STEP;
    localparam int LAT   = ITERS + 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [W-1:0]       in_quot = '0;
    logic [W-1:0]       in_divisor = '0;
    logic [W-1:0]       in_rem = '0;
    logic [TAG_W-1:0]   in_tag = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [2*W-1:0]     out_result;
    logic [TAG_W-1:0]   out_tag;
`ifdef DIV_RECON_CHECK_EN
    logic [W-1:0]       in_dividend = '0;
    logic               out_mismatch;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    div_recon_mul #(.W(W), .STEP(STEP), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_quot    (in_quot),
        .in_divisor (in_divisor),
        .in_rem     (in_rem),
        .in_tag     (in_tag),
`ifdef DIV_RECON_CHECK_EN
        .in_dividend  (in_dividend),
        .out_mismatch (out_mismatch),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
    );

    function automatic logic signed [2*W-1:0] model(input logic signed [W-1:0] q,
                                                    input logic signed [W-1:0] d,
                                                    input logic signed [W-1:0] r);
        logic signed [2*W-1:0] qe, de, re;
        qe = q;
        de = d;
        re = r;
        return qe * de + re;
    endfunction

    function automatic logic [W-1:0] rand_op();
        logic [63:0] t;
        logic [W-1:0] v;
        t = {$urandom(), $urandom()};
        case ($urandom_range(0, 7))
            0: v = {1'b1, {(W-1){1'b0}}};
            1: v = {1'b0, {(W-1){1'b1}}};
            2: v = '0;
            3: v = {W{1'b1}};
            4: v = W'($urandom_range(0, 300)) - W'(150);
            default: v = t[W-1:0];
        endcase
        return v;
    endfunction

    // Drives one operation, counts edges from the acceptance edge (edge 1) to out_valid, then consumes it.
    task automatic run_op(input logic [W-1:0] q, input logic [W-1:0] d, input logic [W-1:0] r,
                          input logic [TAG_W-1:0] tag, input logic [W-1:0] dividend,
                          output logic [2*W-1:0] res, output logic [TAG_W-1:0] tg,
                          output logic mis, output int lat, output bit to);
        int n;
        to = 1'b0;
        mis = 1'b0;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) to = 1'b1;
        in_quot = q; in_divisor = d; in_rem = r; in_tag = tag;
`ifdef DIV_RECON_CHECK_EN
        in_dividend = dividend;
`endif
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_quot = rand_op(); in_divisor = rand_op(); in_rem = rand_op();
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        if (!out_valid) to = 1'b1;
        res = out_result;
        tg  = out_tag;
`ifdef DIV_RECON_CHECK_EN
        mis = out_mismatch;
`else
        mis = (dividend != dividend);
`endif
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++;
        if (out_result !== '0) begin failures++; $display("FAIL reset_out_result got=%h exp=0", out_result); end
        checks++;
        if (out_tag !== '0) begin failures++; $display("FAIL reset_out_tag got=%h exp=0", out_tag); end
    endtask

    task automatic test_directed();
        logic [W-1:0] qv [6];
        logic [W-1:0] dv [6];
        logic [W-1:0] rv [6];
        logic [2*W-1:0] ev [6];
        logic [2*W-1:0] res;
        logic [TAG_W-1:0] tg;
        logic mis;
        int lat;
        bit to;
        qv[0] = 35'd5;                 dv[0] = 35'd7;                       rv[0] = 35'd3;                 ev[0] = 70'd38;
        qv[1] = -35'sd5;               dv[1] = 35'd7;                       rv[1] = -35'sd3;               ev[1] = 70'h3F_FFFF_FFFF_FFFF_FFDA;
        qv[2] = 35'd0;                 dv[2] = -35'sd9;                     rv[2] = -35'sd4;               ev[2] = -70'sd4;
        qv[3] = {1'b1, 34'd0};         dv[3] = {1'b1, 34'd0};               rv[3] = 35'd0;                 ev[3] = 70'h10_0000_0000_0000_0000;
        qv[4] = {1'b1, 34'd0};         dv[4] = {1'b0, {34{1'b1}}};          rv[4] = -(35'h4_0000_0000 - 35'd2);
        ev[4] = -70'sh10_0000_0000_0000_0000 + 70'sd2;
        qv[5] = 35'd3;                 dv[5] = -35'sd4;                     rv[5] = 35'd1;                 ev[5] = -70'sd11;
        for (int i = 0; i < 6; i++) begin
            run_op(qv[i], dv[i], rv[i], TAG_W'(35'h1A + i), ev[i][W-1:0], res, tg, mis, lat, to);
            checks++;
            if (to) begin failures++; $display("FAIL directed_timeout idx=%0d", i); end
            checks++;
            if (res !== ev[i]) begin failures++; $display("FAIL directed_result idx=%0d got=%h exp=%h", i, res, ev[i]); end
            checks++;
            if (tg !== TAG_W'(35'h1A + i)) begin failures++; $display("FAIL directed_tag idx=%0d got=%h exp=%h", i, tg, TAG_W'(35'h1A + i)); end
            checks++;
            if (lat != LAT) begin failures++; $display("FAIL directed_latency idx=%0d got=%0d exp=%0d", i, lat, LAT); end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] q, d, r, dv;
        logic [TAG_W-1:0] tag;
        logic [2*W-1:0] res, exp_res;
        logic [TAG_W-1:0] tg;
        logic mis;
        int lat;
        bit to;
        for (int i = 0; i < 40; i++) begin
            q = rand_op(); d = rand_op(); r = rand_op();
            tag = TAG_W'({$urandom(), $urandom()});
            exp_res = model(q, d, r);
            dv = ($urandom_range(0, 1) == 1) ? exp_res[W-1:0] : rand_op();
            run_op(q, d, r, tag, dv, res, tg, mis, lat, to);
            checks++;
            if (to || res !== exp_res || tg !== tag) begin
                failures++;
                $display("FAIL random idx=%0d q=%h d=%h r=%h got=%h exp=%h tag_got=%h tag_exp=%h to=%0d",
                         i, q, d, r, res, exp_res, tg, tag, to);
            end
`ifdef DIV_RECON_CHECK_EN
            checks++;
            if (mis !== (exp_res != {{W{dv[W-1]}}, dv})) begin
                failures++;
                $display("FAIL random_mismatch idx=%0d got=%b exp=%b", i, mis, exp_res != {{W{dv[W-1]}}, dv});
            end
`endif
        end
    endtask

    task automatic test_back_pressure();
        logic [2*W-1:0] snap_res, exp_res;
        logic [TAG_W-1:0] snap_tag;
        int n;
        exp_res = model(35'd1234, -35'sd77, 35'd9);
        in_quot = 35'd1234; in_divisor = -35'sd77; in_rem = 35'd9; in_tag = 35'h5A5;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
        checks++;
        if (!out_valid || out_result !== exp_res) begin
            failures++; $display("FAIL bp_result got=%h exp=%h valid=%b", out_result, exp_res, out_valid);
        end
        snap_res = out_result;
        snap_tag = out_tag;
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            in_quot = rand_op(); in_divisor = rand_op(); in_rem = rand_op(); in_tag = TAG_W'($urandom());
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_result !== snap_res || out_tag !== snap_tag || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d valid=%b res=%h exp=%h tag=%h exp=%h in_ready=%b exp=0",
                         i, out_valid, out_result, snap_res, out_tag, snap_tag, in_ready);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++; $display("FAIL bp_release in_ready=%b exp=1 out_valid=%b exp=0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [2*W-1:0] res;
        logic [TAG_W-1:0] tg;
        logic mis;
        int lat;
        bit to;
        bit seen;
        in_quot = 35'd999; in_divisor = 35'd999; in_rem = 35'd1; in_tag = 35'h77;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL midrst_state out_valid=%b exp=0 in_ready=%b exp=1", out_valid, in_ready);
        end
        seen = 1'b0;
        for (int i = 0; i < LAT + 5; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin failures++; $display("FAIL midrst_no_pulse got=1 exp=0"); end
        run_op(35'd3, -35'sd4, 35'd1, 35'h3C, -35'sd11, res, tg, mis, lat, to);
        checks++;
        if (to || res !== -70'sd11 || tg !== 35'h3C) begin
            failures++; $display("FAIL midrst_fresh got=%h exp=%h tag=%h to=%0d", res, -70'sd11, tg, to);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_pressure();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
